// File: rtl/food_placer.sv
// food_placer: draws (x,y) candidates from the random source, rejects out-of-range or occupied cells, publishes food.
// Optional macro FOOD_SCAN_EN: after MAX_TRIES failed draws, linearly scan the grid for a free cell.
`timescale 1ns/1ps
module food_placer #(
  parameter int GRID_W    = 20,
  parameter int GRID_H    = 15,
  parameter int MAX_TRIES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       place_req,
  input  logic [3:0] rng4,
  input  logic [4:0] rng5,
  output logic       rng_update,
  output logic       occ_query,
  output logic [4:0] occ_x,
  output logic [3:0] occ_y,
  input  logic       occ_hit,
  output logic [4:0] food_x,
  output logic [3:0] food_y,
  output logic       food_valid,
  output logic       busy,
  output logic       done,
  output logic       fail
);
  localparam int TW = $clog2(MAX_TRIES + 1);
  localparam logic [5:0] GW = 6'(GRID_W);
  localparam logic [4:0] GH = 5'(GRID_H);

`ifdef FOOD_SCAN_EN
  localparam int CELLS = GRID_W * GRID_H;
  localparam int SW    = $clog2(CELLS);
  typedef enum logic [2:0] {IDLE, DRAW, SAMPLE, QUERY, WAIT, SCAN_Q, SCAN_W} state_t;
  localparam state_t EXH_ST = SCAN_Q;
`else
  typedef enum logic [2:0] {IDLE, DRAW, SAMPLE, QUERY, WAIT} state_t;
  localparam state_t EXH_ST = IDLE;
`endif

  state_t state, state_d;
  logic [TW-1:0] tries;
  logic [4:0] cand_x;
  logic [3:0] cand_y;
  logic in_range, last_try, exhaust, success;

  assign in_range = ({1'b0, rng5} < GW) && ({1'b0, rng4} < GH);
  assign last_try = (tries == TW'(MAX_TRIES - 1));
  assign exhaust  = last_try && ((state == SAMPLE && !in_range) || (state == WAIT && occ_hit));
  assign occ_x    = cand_x;
  assign occ_y    = cand_y;

`ifdef FOOD_SCAN_EN
  logic [SW-1:0] scan_cnt;
  logic scan_last, row_end;
  logic [4:0] nx;
  logic [3:0] ny;
  assign success   = !occ_hit && (state == WAIT || state == SCAN_W);
  assign scan_last = (scan_cnt == SW'(CELLS - 1));
  // Scan order: x fastest, wrapping into the next row, last row wraps to row 0.
  assign row_end   = (cand_x == 5'(GRID_W - 1));
  assign nx        = row_end ? 5'd0 : cand_x + 5'd1;
  assign ny        = !row_end ? cand_y : (cand_y == 4'(GRID_H - 1)) ? 4'd0 : cand_y + 4'd1;
`else
  assign success   = !occ_hit && (state == WAIT);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (place_req) state_d = DRAW;
      DRAW:    state_d = SAMPLE;
      SAMPLE:  state_d = in_range ? QUERY : (last_try ? EXH_ST : DRAW);
      QUERY:   state_d = WAIT;
      WAIT:    state_d = !occ_hit ? IDLE : (last_try ? EXH_ST : DRAW);
`ifdef FOOD_SCAN_EN
      SCAN_Q:  state_d = SCAN_W;
      SCAN_W:  state_d = (!occ_hit || scan_last) ? IDLE : SCAN_Q;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rng_update = (state == DRAW);
    busy       = (state != IDLE);
`ifdef FOOD_SCAN_EN
    occ_query  = (state == QUERY) || (state == SCAN_Q);
`else
    occ_query  = (state == QUERY);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tries      <= '0;
      cand_x     <= '0;
      cand_y     <= '0;
      food_x     <= '0;
      food_y     <= '0;
      food_valid <= 1'b0;
      done       <= 1'b0;
      fail       <= 1'b0;
`ifdef FOOD_SCAN_EN
      scan_cnt   <= '0;
`endif
    end else begin
      done <= success;
`ifdef FOOD_SCAN_EN
      fail <= (state == SCAN_W) && occ_hit && scan_last;
      if (exhaust) scan_cnt <= '0;
      else if (state == SCAN_W && occ_hit) begin
        scan_cnt <= scan_cnt + SW'(1);
        cand_x   <= nx;
        cand_y   <= ny;
      end
`else
      fail <= exhaust;
`endif
      // cand only tracks in-range draws so a scan starts from the last real candidate.
      if (state == IDLE && place_req) begin
        food_valid <= 1'b0;
        tries      <= '0;
        cand_x     <= '0;
        cand_y     <= '0;
      end
      if (state == SAMPLE && in_range) begin
        cand_x <= rng5;
        cand_y <= rng4;
      end
      if ((state == SAMPLE && !in_range) || (state == WAIT && occ_hit)) tries <= tries + TW'(1);
      if (success) begin
        food_x     <= cand_x;
        food_y     <= cand_y;
        food_valid <= 1'b1;
      end
    end
  end
endmodule
